// File: rtl/obi_pkg.sv
// Shared types and helpers for OBI slave-side responders.
package obi_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } obi_tag_t;

    // True when addr falls inside the window of 2**aw words that starts at base.
    function automatic logic obi_addr_hit(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned aw);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (aw + 2);
        return ((addr ^ base) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI request/response channel between an interconnect slave port and a responder.
interface obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_rsp_fifo.sv
// Synchronous FIFO of OBI responses; any depth, pointers wrap on an explicit count.
module obi_rsp_fifo
    import obi_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  obi_rsp_t         wdata,
    input  logic             pop,
    output obi_rsp_t         rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    obi_rsp_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; an entry is only observed once count_q marks it valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_mem_responder.sv
// OBI slave responder in front of a fixed-latency synchronous memory, with
// out-of-window error responses, an in-order response FIFO and credit-based granting.
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH = 4096,
    parameter  logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter  int unsigned MEM_LAT   = 1,
    parameter  int unsigned RSP_DEPTH = 2,
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    obi_mem_responder_if.slave bus,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic             hit;
    logic             gnt;
    logic             accept;
    logic             pop;
    logic             push;
    logic             rvalid;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    obi_tag_t         tag_q [MEM_LAT];
    obi_tag_t         tag_last;
    obi_rsp_t         push_rsp;
    obi_rsp_t         head_rsp;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Credits cover both the latency pipeline and the FIFO, so grant never looks at rready.
    assign hit    = obi_addr_hit(bus.addr, BASE_ADDR, ADDR_W);
    assign gnt    = bus.req && (outstanding_q < CNT_W'(RSP_DEPTH));
    assign accept = bus.req && gnt;
    assign bus.gnt = gnt;

    assign mem_req_o   = accept && hit;
    assign mem_we_o    = bus.we;
    assign mem_be_o    = bus.be;
    assign mem_addr_o  = bus.addr[ADDR_W+1:2];
    assign mem_wdata_o = bus.wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: accept, we: bus.we, err: !hit};
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // The last stage lines up with the cycle in which the memory presents read data.
    assign tag_last       = tag_q[MEM_LAT-1];
    assign push           = tag_last.valid;
    assign push_rsp.rdata = (tag_last.we || tag_last.err) ? 32'h0 : mem_rdata_i;
    assign push_rsp.err   = tag_last.err;

    obi_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .wdata (push_rsp),
        .pop   (pop),
        .rdata (head_rsp),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rvalid     = !fifo_empty;
    assign pop        = rvalid && bus.rready;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rvalid ? head_rsp.rdata : 32'h0;
    assign bus.err    = rvalid && head_rsp.err;

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves it unassigned (no latch).
        outstanding_d = outstanding_q;
        unique case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    push_never_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full));

    queued_within_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= outstanding_q);

endmodule

// File: tb/tb_obi_mem_responder.sv
// Drives three responder configurations from one stimulus stream and checks them
// against a queue-based model of in-order, fixed-latency responses.
module tb_obi_mem_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rready;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          ready;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_mreq;
        logic [11:0] exp_maddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003));
    endfunction

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(WORDS * 4));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) tick();
    endtask

    // Instance 0: LAT 1 / depth 2; instance 1: LAT 3 / depth 5; instance 2: LAT 1 / depth 3.
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 1) ? 3 : 1;
        localparam int DEP = (g == 0) ? 2 : ((g == 1) ? 5 : 3);

        obi_mem_responder_if bus();
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [11:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;

        assign bus.req    = req;
        assign bus.addr   = addr;
        assign bus.we     = we;
        assign bus.be     = be;
        assign bus.wdata  = wdata;
        assign bus.rready = rready;

        obi_mem_responder #(
            .MEM_DEPTH (WORDS),
            .BASE_ADDR (BASE),
            .MEM_LAT   (LAT),
            .RSP_DEPTH (DEP)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .bus         (bus),
            .mem_req_o   (mem_req),
            .mem_we_o    (mem_we),
            .mem_be_o    (mem_be),
            .mem_addr_o  (mem_addr),
            .mem_wdata_o (mem_wdata),
            .mem_rdata_i (mem_rdata)
        );

        // Memory macro: byte-enabled writes, reads delivered LAT cycles after the strobe.
        logic [31:0] mem [WORDS];
        logic [31:0] rd_pipe [LAT];
        always @(posedge clk) begin
            if (mem_req && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            rd_pipe[0] <= (mem_req && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign mem_rdata = rd_pipe[LAT-1];

        // Reference model: what was accepted, and when each response may appear.
        logic [31:0] ref_mem [WORDS];
        exp_t        exp_q [$];
        int          outst;
        logic        exp_gnt;
        logic        exp_rv;
        logic        acc;
        logic        pop;
        exp_t        e;
        logic [11:0] widx;

        initial begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i]     = init_word(i);
                ref_mem[i] = init_word(i);
            end
            outst = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    outst = 0;
                    check($sformatf("i%0d reset rvalid", g), 32'(bus.rvalid), 32'd0);
                    check($sformatf("i%0d reset rdata", g), bus.rdata, 32'd0);
                    check($sformatf("i%0d reset err", g), 32'(bus.err), 32'd0);
                end else begin
                    exp_gnt = req && (outst < DEP);
                    check($sformatf("i%0d gnt", g), 32'(bus.gnt), 32'(exp_gnt));
                    exp_rv = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
                    check($sformatf("i%0d rvalid", g), 32'(bus.rvalid), 32'(exp_rv));
                    if (exp_rv) begin
                        check($sformatf("i%0d rdata", g), bus.rdata, exp_q[0].rdata);
                        check($sformatf("i%0d err", g), 32'(bus.err), 32'(exp_q[0].err));
                    end
                    acc = exp_gnt;
                    pop = exp_rv && rready;
                    if (acc) begin
                        widx    = addr[13:2];
                        e.err   = !in_window(addr);
                        e.rdata = (we || e.err) ? 32'h0 : ref_mem[widx];
                        e.ready = cyc + LAT + 1;
                        exp_q.push_back(e);
                        check($sformatf("i%0d mem_req", g), 32'(mem_req), 32'(!e.err));
                        if (!e.err) begin
                            check($sformatf("i%0d mem_addr", g), 32'(mem_addr), 32'(widx));
                            check($sformatf("i%0d mem_we", g), 32'(mem_we), 32'(we));
                            check($sformatf("i%0d mem_be", g), 32'(mem_be), 32'(be));
                            check($sformatf("i%0d mem_wdata", g), mem_wdata, wdata);
                            if (we) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (be[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
                                end
                            end
                        end
                    end else begin
                        check($sformatf("i%0d mem_req idle", g), 32'(mem_req), 32'd0);
                    end
                    if (pop) void'(exp_q.pop_front());
                    outst = outst + int'(acc) - int'(pop);
                end
            end
        end
    end

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before 500us");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] v4;
        int          grants;
        logic        last_gnt;
        int          first_c, cnt_c, last_c, first_b, cnt_b, last_b;
        int          seen, seen_at;
        logic [31:0] seen_dat;
        int          pick;

        v4 = init_word(4);
        vecs[0] = '{32'h1000_0004, 1'b0, 4'hF, 32'h0,          1'b1, 12'd1,     32'hDEAD_BEEF,            1'b0};
        vecs[1] = '{32'h1000_0010, 1'b1, 4'h3, 32'h1234_5678,  1'b1, 12'd4,     32'h0,                    1'b0};
        vecs[2] = '{32'h1000_0010, 1'b0, 4'hF, 32'h0,          1'b1, 12'd4,     {v4[31:16], 16'h5678},    1'b0};
        vecs[3] = '{32'h2000_0000, 1'b0, 4'hF, 32'h0,          1'b0, 12'd0,     32'h0,                    1'b1};
        vecs[4] = '{32'h0FFF_FFFC, 1'b1, 4'hF, 32'hFFFF_FFFF,  1'b0, 12'd0,     32'h0,                    1'b1};
        vecs[5] = '{32'h1000_3FFF, 1'b0, 4'hF, 32'h0,          1'b1, 12'hFFF,   init_word(4095),          1'b0};
        vecs[6] = '{32'h1000_4000, 1'b0, 4'hF, 32'h0,          1'b0, 12'd0,     32'h0,                    1'b1};
        vecs[7] = '{32'h1000_0003, 1'b0, 4'hF, 32'h0,          1'b1, 12'd0,     init_word(0),             1'b0};

        rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rready = 1'b1;
        repeat (3) tick();
        check("reset gnt with req low", 32'(g_inst[0].bus.gnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single transactions on the LAT 1 / depth 2 instance.
        foreach (vecs[i]) begin
            req = 1'b1; addr = vecs[i].addr; we = vecs[i].we; be = vecs[i].be; wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d gnt", i), 32'(g_inst[0].bus.gnt), 32'd1);
            check($sformatf("vec%0d mem_req", i), 32'(g_inst[0].mem_req), 32'(vecs[i].exp_mreq));
            if (vecs[i].exp_mreq) begin
                check($sformatf("vec%0d mem_addr", i), 32'(g_inst[0].mem_addr), 32'(vecs[i].exp_maddr));
                check($sformatf("vec%0d mem_we", i), 32'(g_inst[0].mem_we), 32'(vecs[i].we));
                check($sformatf("vec%0d mem_be", i), 32'(g_inst[0].mem_be), 32'(vecs[i].be));
            end
            tick();
            req = 1'b0;
            #1;
            check($sformatf("vec%0d rvalid early", i), 32'(g_inst[0].bus.rvalid), 32'd0);
            tick();
            #1;
            check($sformatf("vec%0d rvalid", i), 32'(g_inst[0].bus.rvalid), 32'd1);
            check($sformatf("vec%0d rdata", i), g_inst[0].bus.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(g_inst[0].bus.err), 32'(vecs[i].exp_err));
            tick();
            #1;
            check($sformatf("vec%0d rvalid popped", i), 32'(g_inst[0].bus.rvalid), 32'd0);
            we = 1'b0;
        end
        idle(8);

        // Back-pressure: credits run out after two accepts with rready low.
        rready = 1'b0;
        grants = 0;
        last_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; addr = BASE + 32'((32 + grants) * 4); we = 1'b0; be = 4'hF;
            #1;
            last_gnt = g_inst[0].bus.gnt;
            if (last_gnt) grants++;
            tick();
        end
        addr = BASE + 32'((32 + grants) * 4);
        #1;
        check("bp grants", 32'(grants), 32'd2);
        check("bp gnt exhausted", 32'(last_gnt), 32'd0);
        check("bp rvalid held", 32'(g_inst[0].bus.rvalid), 32'd1);
        check("bp head", g_inst[0].bus.rdata, init_word(32));
        rready = 1'b1;
        #1;
        check("bp gnt before pop", 32'(g_inst[0].bus.gnt), 32'd0);
        tick();
        #1;
        check("bp gnt after pop", 32'(g_inst[0].bus.gnt), 32'd1);
        tick();
        idle(12);

        // Streaming reads of words 0..7 with rready high.
        first_c = -1; cnt_c = 0; last_c = -1; first_b = -1; cnt_b = 0; last_b = -1;
        for (int j = 0; j < 16; j++) begin
            req = (j < 8); addr = BASE + 32'(j * 4); we = 1'b0; be = 4'hF;
            #1;
            if (j < 8) begin
                check($sformatf("stream gnt lat1 %0d", j), 32'(g_inst[2].bus.gnt), 32'd1);
                check($sformatf("stream gnt lat3 %0d", j), 32'(g_inst[1].bus.gnt), 32'd1);
            end
            if (g_inst[2].bus.rvalid) begin
                if (first_c < 0) first_c = j;
                cnt_c++; last_c = j;
            end
            if (g_inst[1].bus.rvalid) begin
                if (first_b < 0) first_b = j;
                cnt_b++; last_b = j;
            end
            tick();
        end
        check("stream lat1 first rvalid", 32'(first_c), 32'd2);
        check("stream lat1 count", 32'(cnt_c), 32'd8);
        check("stream lat1 contiguous", 32'(last_c - first_c), 32'd7);
        check("stream lat3 first rvalid", 32'(first_b), 32'd4);
        check("stream lat3 count", 32'(cnt_b), 32'd8);
        check("stream lat3 contiguous", 32'(last_b - first_b), 32'd7);
        idle(12);

        // Reset with two responses queued.
        rready = 1'b0;
        req = 1'b1; addr = BASE + 32'h4; we = 1'b0; be = 4'hF;
        tick();
        addr = BASE + 32'h8;
        tick();
        req = 1'b0;
        tick();
        tick();
        check("rst queued rvalid", 32'(g_inst[0].bus.rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst rvalid lat1d2", 32'(g_inst[0].bus.rvalid), 32'd0);
        check("rst rvalid lat3", 32'(g_inst[1].bus.rvalid), 32'd0);
        check("rst rvalid lat1d3", 32'(g_inst[2].bus.rvalid), 32'd0);
        check("rst rdata", g_inst[0].bus.rdata, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rready = 1'b1;
        tick();
        seen = 0; seen_at = -1; seen_dat = '0;
        for (int j = 0; j < 6; j++) begin
            req = (j == 0); addr = BASE + 32'h4; we = 1'b0;
            #1;
            if (g_inst[0].bus.rvalid) begin
                seen++; seen_at = j; seen_dat = g_inst[0].bus.rdata;
            end
            tick();
        end
        check("post-rst response count", 32'(seen), 32'd1);
        check("post-rst response cycle", 32'(seen_at), 32'd2);
        check("post-rst response data", seen_dat, 32'hDEAD_BEEF);
        idle(4);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            pick   = int'($urandom_range(0, 9));
            req    = ($urandom_range(0, 9) < 7);
            rready = ($urandom_range(0, 9) < 7);
            we     = $urandom_range(0, 1) == 1;
            be     = 4'($urandom);
            wdata  = $urandom;
            case (pick)
                0, 1, 2, 3, 4, 5: addr = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                6:                addr = BASE + 32'h3FFC;
                7:                addr = BASE + 32'h4000 + 32'($urandom_range(0, 255));
                8:                addr = BASE - 32'h4;
                default:          addr = $urandom;
            endcase
            tick();
        end
        rready = 1'b1;
        we = 1'b0;
        idle(20);
        check("drained lat1d2", 32'(g_inst[0].bus.rvalid), 32'd0);
        check("drained lat3", 32'(g_inst[1].bus.rvalid), 32'd0);
        check("drained lat1d3", 32'(g_inst[2].bus.rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
